// File: rtl/lolap_inv_iter.sv
// Iterative inverse of the 257-bit LolaP permutation: UNROLL inverse rounds per
// clock over NR_ROUNDS/UNROLL cycles, valid/ready on both sides.
module lolap_inv_iter #(
  parameter int NR_ROUNDS = 8,
  parameter int UNROLL    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [256:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [256:0] out_data,
  output logic         busy
);

  localparam int NCYC = NR_ROUNDS / UNROLL;
  localparam int CW   = $clog2(NCYC) + 1;

  if ((NR_ROUNDS % UNROLL) != 0) begin : g_bad_unroll
    $error("lolap_inv_iter: NR_ROUNDS must be a multiple of UNROLL");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [256:0]  state_q, state_d;
  logic [256:0]  inv_out;

  // Round constant for forward round r; must match the forward LolaP chain.
  function automatic logic [256:0] rc(input int r);
    return {1'b1, {4{64'h9E37_79B9_7F4A_7C15}}} ^
           {225'd0, 32'(r) * 32'h2545_F491 + 32'h1};
  endfunction

  // Forward round: a = x + rc; b = a ^ (a << 64); y = rotl(b, 29).
  function automatic logic [256:0] round_inv(input logic [256:0] y, input int r);
    logic [256:0] b, a;
    b = {y[28:0], y[256:29]};
    a = b ^ (b << 64) ^ (b << 128) ^ (b << 192) ^ (b << 256);
    return a - rc(r);
  endfunction

  // Rounds are undone last-first: cycle cnt covers rounds NR-1-cnt*UNROLL downward.
  always_comb begin
    inv_out = state_q;
    for (int u = 0; u < UNROLL; u++)
      inv_out = round_inv(inv_out, NR_ROUNDS - 1 - int'(cnt_q) * UNROLL - u);
  end

  assign in_ready  = (st_q == IDLE) || ((st_q == DONE) && out_ready);
  assign out_valid = (st_q == DONE);
  assign out_data  = state_q;
  assign busy      = (st_q == RUN);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (st_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          cnt_d   = '0;
          st_d    = RUN;
        end
      end
      RUN: begin
        state_d = inv_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCYC - 1)) st_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = in_data;
            cnt_d   = '0;
            st_d    = RUN;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_lolap_inv_iter.sv
// Scoreboard bench for lolap_inv_iter: forward LolaP model feeds the DUT,
// recovered x and first-valid latency are checked on each output handshake.
module tb_lolap_inv_iter;

  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [256:0] in_data, out_data;
  logic         v4_in_valid, v4_in_ready, v4_out_valid, v4_out_ready, v4_busy;
  logic [256:0] v4_in_data, v4_out_data;

  lolap_inv_iter #(.NR_ROUNDS(NR), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  lolap_inv_iter #(.NR_ROUNDS(NR), .UNROLL(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4_in_valid), .in_ready(v4_in_ready), .in_data(v4_in_data),
    .out_valid(v4_out_valid), .out_ready(v4_out_ready), .out_data(v4_out_data),
    .busy(v4_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_out   = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [256:0] rc(input int r);
    return {1'b1, {4{64'h9E37_79B9_7F4A_7C15}}} ^
           {225'd0, 32'(r) * 32'h2545_F491 + 32'h1};
  endfunction

  function automatic logic [256:0] lolap_fwd(input logic [256:0] x);
    logic [256:0] a, b;
    for (int r = 0; r < NR; r++) begin
      a = x + rc(r);
      b = a ^ (a << 64);
      x = {b[227:0], b[256:228]};
    end
    return x;
  endfunction

  function automatic logic [256:0] rand257();
    logic [256:0] x = '0;
    for (int k = 0; k < 9; k++) x = {x[224:0], 32'($urandom)};
    return x;
  endfunction

  typedef struct {
    logic [256:0] x;
    int           t;
  } exp_t;

  exp_t         q[$];
  logic [256:0] cur_x;
  int           ov_cyc = 0;
  logic         ov_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) q.push_back('{cur_x, cyc});
      if (out_valid && !ov_prev) ov_cyc = cyc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 257'd1, 257'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", out_data, e.x);
          chk("latency", 257'(ov_cyc - e.t), 257'(NR + 1));
          n_out++;
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [256:0] x, input logic hold);
    logic acc = 1'b0;
    cur_x    = x;
    in_data  = lolap_fwd(x);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1'b1; break; end
    end
    if (!acc) chk("send_timeout", 257'd0, 257'd1);
    last_acc = cyc;
    @(posedge clk); #1;
    if (!hold || !acc) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 257'(q.size()), 257'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [256:0] x;
    int t0, n0, ta;
    in_valid = 0; in_data = '0; out_ready = 1; cur_x = '0;
    v4_in_valid = 0; v4_in_data = '0; v4_out_ready = 1;

    // reset values
    #3;
    chk("rst_in_ready", 257'(in_ready), 257'd1);
    chk("rst_out_valid", 257'(out_valid), 257'd0);
    chk("rst_out_data", out_data, 257'd0);
    chk("rst_busy", 257'(busy), 257'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // round trips, sequential and with handover at DONE
    send(257'h1, 0);
    wait_drain();
    send(257'h0, 0);
    send({257{1'b1}}, 0);
    for (int k = 0; k < 200; k++) send(rand257(), 0);
    wait_drain();

    // backpressure
    out_ready = 0;
    x = rand257();
    send(x, 0);
    @(negedge clk);
    chk("busy_run", 257'(busy), 257'd1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 257'(out_valid), 257'd1);
      chk("bp_data", out_data, x);
      chk("bp_in_ready", 257'(in_ready), 257'd0);
      chk("bp_busy", 257'(busy), 257'd0);
      @(posedge clk); #1;
      in_valid = k[0];
      in_data  = rand257();
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_valid", 257'(out_valid), 257'd0);
    chk("bp_idle_ready", 257'(in_ready), 257'd1);
    chk("bp_idle_busy", 257'(busy), 257'd0);
    wait_drain();

    // back-to-back with in_valid held
    n0 = n_out;
    send(rand257(), 1);
    t0 = last_acc;
    send(rand257(), 1);
    chk("b2b_gap1", 257'(last_acc - t0), 257'(NR + 1));
    t0 = last_acc;
    send(rand257(), 0);
    chk("b2b_gap2", 257'(last_acc - t0), 257'(NR + 1));
    wait_drain();
    chk("b2b_count", 257'(n_out - n0), 257'd3);

    // reset mid-RUN at cnt=4
    send(rand257(), 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    q.delete();
    chk("mid_rst_in_ready", 257'(in_ready), 257'd1);
    chk("mid_rst_out_valid", 257'(out_valid), 257'd0);
    chk("mid_rst_out_data", out_data, 257'd0);
    chk("mid_rst_busy", 257'(busy), 257'd0);
    @(posedge clk); #1 rst_n = 1;
    n0 = n_out;
    send(rand257(), 0);
    wait_drain();
    chk("post_rst_count", 257'(n_out - n0), 257'd1);

    // UNROLL=4 instance: 3-cycle latency, same recovered x
    for (int k = 0; k < 3; k++) begin
      x = (k == 0) ? 257'h1 : rand257();
      v4_in_data  = lolap_fwd(x);
      v4_in_valid = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (v4_in_ready) break;
      end
      ta = cyc;
      @(posedge clk); #1 v4_in_valid = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (v4_out_valid) break;
      end
      chk("u4_latency", 257'(cyc - ta), 257'd3);
      chk("u4_data", v4_out_data, x);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
